// File: rtl/sub8_pkg.sv
// Shared constants and types for the bit-serial subtractor.
// The build macro SUB8_SERIAL_OVERFLOW_EN adds the signed overflow output.
package sub8_pkg;

  // Default operand/result width in bits.
  localparam int SUB8_WIDTH = 8;

  // Bit-counter width for the default width.
  localparam int SUB8_CNT_W = $clog2(SUB8_WIDTH);

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor used by the bit-serial datapath.
module full_subtractor (
  input  logic x,
  input  logic y,
  input  logic bi,
  output logic d,
  output logic bo
);

  // Difference bit and borrow out for x - y - bi.
  always_comb begin
    d  = x ^ y ^ bi;
    bo = (~x & y) | (~(x ^ y) & bi);
  end

endmodule

// File: rtl/sub8_serial.sv
// Bit-serial subtractor: diff = a - b - bin, one bit per cycle, LSB first.
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high; in_ready is high only in IDLE, out_valid only in DONE, and the result
// is held stable in DONE until out_ready is seen.
// Build macro SUB8_SERIAL_OVERFLOW_EN adds the ovf output (signed overflow).
// dbg_state exposes the controller state for checkers.
module sub8_serial
  import sub8_pkg::*;
#(
  parameter int WIDTH = SUB8_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
`ifdef SUB8_SERIAL_OVERFLOW_EN
  output logic             ovf,
`endif
  output logic [1:0]       dbg_state
);

  localparam int CW = (WIDTH == SUB8_WIDTH) ? SUB8_CNT_W : $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             br_q, br_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bout_q, bout_d;
`ifdef SUB8_SERIAL_OVERFLOW_EN
  logic             ovf_q, ovf_d;
`endif

  logic fs_d, fs_bo;

  full_subtractor u_fs (
    .x  (a_q[0]),
    .y  (b_q[0]),
    .bi (br_q),
    .d  (fs_d),
    .bo (fs_bo)
  );

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      br_q    <= 1'b0;
      diff_q  <= '0;
      bout_q  <= 1'b0;
`ifdef SUB8_SERIAL_OVERFLOW_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      br_q    <= br_d;
      diff_q  <= diff_d;
      bout_q  <= bout_d;
`ifdef SUB8_SERIAL_OVERFLOW_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Next-state and datapath: capture in IDLE, one bit per SHIFT cycle, hold in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    br_d    = br_q;
    diff_d  = diff_q;
    bout_d  = bout_q;
`ifdef SUB8_SERIAL_OVERFLOW_EN
    ovf_d   = ovf_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          br_d    = bin;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        // Result bits enter at the MSB so the word is aligned after WIDTH bits.
        diff_d = {fs_d, diff_q[WIDTH-1:1]};
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        br_d   = fs_bo;
        if (cnt_q == LAST_BIT) begin
          bout_d  = fs_bo;
`ifdef SUB8_SERIAL_OVERFLOW_EN
          // br_q is the borrow into the MSB on the last bit.
          ovf_d   = br_q ^ fs_bo;
`endif
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = diff_q;
  assign bout      = bout_q;
`ifdef SUB8_SERIAL_OVERFLOW_EN
  assign ovf       = ovf_q;
`endif
  assign dbg_state = state_q;

endmodule

// File: tb/tb_sub8_serial.sv
// Testbench for sub8_serial: directed cases plus random operands checked
// against an arithmetic reference model. Define SUB8_SERIAL_OVERFLOW_EN to
// also exercise the ovf output.
module tb_sub8_serial;

  localparam int W  = 8;
  localparam int EW = W + 2;  // {ovf, bout, diff}

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         bin;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] diff;
  logic         bout;
  logic         ovf_obs;
  logic [1:0]   dbg_state;

  int checks = 0;
  int errors = 0;

  logic [EW-1:0] exp_q[$];

  sub8_serial #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .bin       (bin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .diff      (diff),
    .bout      (bout),
`ifdef SUB8_SERIAL_OVERFLOW_EN
    .ovf       (ovf_obs),
`endif
    .dbg_state (dbg_state)
  );

`ifndef SUB8_SERIAL_OVERFLOW_EN
  assign ovf_obs = 1'b0;
`endif

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain integer arithmetic on the operands.
  function automatic logic [EW-1:0] model(input logic [W-1:0] ai, input logic [W-1:0] bi,
                                          input logic ci);
    int          ua, ub, r, sa, sb, sr;
    logic [W-1:0] d;
    logic         bo, ov;
    ua = int'(ai);
    ub = int'(bi);
    r  = ua - ub - int'(ci);
    d  = W'(r + 256);
    bo = (ua < ub + int'(ci));
    sa = (ua >= 128) ? ua - 256 : ua;
    sb = (ub >= 128) ? ub - 256 : ub;
    sr = sa - sb - int'(ci);
`ifdef SUB8_SERIAL_OVERFLOW_EN
    ov = (sr > 127) || (sr < -128);
`else
    ov = 1'b0;
`endif
    return {ov, bo, d};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
    end
  endtask

  // Driver: one full operation, with the result held for 'hold' cycles of
  // backpressure. With 'poke' set, a foreign in_valid is driven during the hold.
  task automatic run_op(input logic [W-1:0] ai, input logic [W-1:0] bi, input logic ci,
                        input int hold, input bit poke);
    int lat;
    int waited;
    logic [EW-1:0] e;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", 32'(in_ready), 32'd1);
    a = ai; b = bi; bin = ci; in_valid = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk);
    exp_q.push_back(model(ai, bi, ci));
    @(negedge clk);
    in_valid = 1'b0;
    a = W'($urandom); b = W'($urandom); bin = 1'($urandom);
    lat = 1;
    while (!out_valid && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    check("latency", 32'(lat), 32'd9);
    e = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      if (poke) begin
        in_valid = 1'b1; a = 8'd1; b = 8'd1; bin = 1'b0;
      end
      check("hold_diff", 32'(diff), 32'(e[W-1:0]));
      check("hold_bout", 32'(bout), 32'(e[W]));
      check("hold_in_ready", 32'(in_ready), 32'd0);
      check("hold_out_valid", 32'(out_valid), 32'd1);
      @(negedge clk);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    check("diff", 32'(diff), 32'(e[W-1:0]));
    check("bout", 32'(bout), 32'(e[W]));
`ifdef SUB8_SERIAL_OVERFLOW_EN
    check("ovf", 32'(ovf_obs), 32'(e[W+1]));
`endif
    @(negedge clk);
    check("post_out_valid", 32'(out_valid), 32'd0);
    check("post_in_ready", 32'(in_ready), 32'd1);
  endtask

  // Stimulus
  initial begin
    int quiet_viol;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; bin = 1'b0;
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_bout", 32'(bout), 32'd0);
    check("rst_state", 32'(dbg_state), 32'd0);
`ifdef SUB8_SERIAL_OVERFLOW_EN
    check("rst_ovf", 32'(ovf_obs), 32'd0);
`endif
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Accepted on the first edge after release.
    run_op(8'd4, 8'd17, 1'b0, 0, 1'b0);
    check("dir_4_17", 32'(diff), 32'd243);

    // Back-to-back with out_ready tied high.
    run_op(8'd20, 8'd7, 1'b0, 0, 1'b0);
    run_op(8'd62, 8'd51, 1'b1, 0, 1'b0);
    check("dir_62_51", 32'(diff), 32'd10);

    // Backpressure with an ignored in_valid.
    run_op(8'd55, 8'd200, 1'b1, 5, 1'b1);
    check("dir_55_200", 32'(diff), 32'd110);

    // Boundary patterns.
    run_op(8'd127, 8'd255, 1'b0, 0, 1'b0);
    check("dir_127_255", 32'(diff), 32'd128);
    run_op(8'd5, 8'd3, 1'b0, 0, 1'b0);
    run_op(8'd170, 8'd170, 1'b1, 1, 1'b0);
    check("eq_bin1", 32'(diff), 32'd255);
    run_op(8'd99, 8'd0, 1'b0, 0, 1'b0);
    check("b0", 32'(diff), 32'd99);

    // Reset mid-SHIFT.
    a = 8'd100; b = 8'd3; bin = 1'b0; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_abort_state", 32'(dbg_state), 32'd1);
    rst_n = 1'b0;
    #1;
    check("abort_in_ready", 32'(in_ready), 32'd1);
    check("abort_out_valid", 32'(out_valid), 32'd0);
    check("abort_diff", 32'(diff), 32'd0);
    check("abort_bout", 32'(bout), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    quiet_viol = 0;
    for (int i = 0; i < 14; i++) begin
      if (out_valid) quiet_viol++;
      @(negedge clk);
    end
    check("abort_no_result", 32'(quiet_viol), 32'd0);
    run_op(8'd9, 8'd9, 1'b1, 0, 1'b0);
    check("after_abort", 32'(diff), 32'd255);

    // Random operands and random backpressure.
    for (int n = 0; n < 24; n++) begin
      run_op(W'($urandom), W'($urandom), 1'($urandom), $urandom_range(0, 3), 1'($urandom));
    end

    // Report
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global time limit.
  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
